// File: rtl/mmc3_scanline_irq_ctrl.sv
// MMC3 scanline IRQ controller, fully synchronous to M2.
// Filters PPU A12 rises, decodes $C000-$FFFF writes and clocks the 8-bit scanline counter.
`timescale 1ns/1ps

module mmc3_scanline_irq_ctrl #(
  parameter int FILTER_CYCLES = 3,
  parameter int ALT_IRQ       = 0
) (
  input  logic        m2,
  input  logic        rst_n,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  output logic        irq_n,
  output logic [7:0]  irq_counter,
  output logic        a12_event
);

  localparam logic [2:0] FILTER_MAX = 3'(FILTER_CYCLES);

  // A12 synchroniser and low-time filter
  logic       a12_s1;
  logic       a12_s2;
  logic       a12_s3;
  logic [2:0] low_cnt;
  logic       a12_rise;

  assign a12_rise = a12_s2 && !a12_s3 && (low_cnt == FILTER_MAX);

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      a12_s1  <= 1'b0;
      a12_s2  <= 1'b0;
      a12_s3  <= 1'b0;
      low_cnt <= 3'd0;
    end else begin
      a12_s1 <= ppu_a12;
      a12_s2 <= a12_s1;
      a12_s3 <= a12_s2;
      if (a12_s2) begin
        low_cnt <= 3'd0;
      end else if (low_cnt < FILTER_MAX) begin
        low_cnt <= low_cnt + 3'd1;
      end
    end
  end

  // CPU write decode: one commit on the first edge of a write cycle
  logic       wr_cond;
  logic       wr_prev;
  logic       commit;
  logic [2:0] reg_sel;
  logic       wr_latch;
  logic       wr_reload;
  logic       wr_disable;
  logic       wr_enable;
  logic       unused_addr;

  assign wr_cond     = !romsel && !cpu_rw_in;
  assign commit      = wr_cond && !wr_prev;
  assign reg_sel     = {cpu_addr_in[14], cpu_addr_in[13], cpu_addr_in[0]};
  assign wr_latch    = commit && (reg_sel == 3'b100);
  assign wr_reload   = commit && (reg_sel == 3'b101);
  assign wr_disable  = commit && (reg_sel == 3'b110);
  assign wr_enable   = commit && (reg_sel == 3'b111);
  assign unused_addr = ^cpu_addr_in[12:1];

  // Counter clocking and IRQ decision
  logic [7:0] latch;
  logic [7:0] counter;
  logic       reload;
  logic       enabled;
  logic       reload_now;
  logic [7:0] ctr_clocked;
  logic       alt_ok;
  logic       fire;

  assign reload_now  = (counter == 8'd0) || reload;
  assign ctr_clocked = reload_now ? latch : (counter - 8'd1);
  assign alt_ok      = (ALT_IRQ == 0) || (counter != 8'd0) || reload;
  // A coincident $C001 write overrides the clock, so it must also suppress the IRQ.
  assign fire        = a12_rise && !wr_reload && enabled && (ctr_clocked == 8'd0) && alt_ok;

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev   <= 1'b0;
      a12_event <= 1'b0;
      latch     <= 8'd0;
      counter   <= 8'd0;
      reload    <= 1'b0;
      enabled   <= 1'b0;
      irq_n     <= 1'b1;
    end else begin
      wr_prev   <= wr_cond;
      a12_event <= a12_rise;

      if (wr_latch) begin
        latch <= cpu_data_in;
      end

      if (wr_reload) begin
        counter <= 8'd0;
        reload  <= 1'b1;
      end else if (a12_rise) begin
        counter <= ctr_clocked;
        reload  <= 1'b0;
      end

      if (wr_disable) begin
        enabled <= 1'b0;
        irq_n   <= 1'b1;
      end else begin
        if (wr_enable) begin
          enabled <= 1'b1;
        end
        if (fire) begin
          irq_n <= 1'b0;
        end
      end
    end
  end

  assign irq_counter = counter;

endmodule

// File: tb/tb_mmc3_scanline_irq_ctrl.sv
// Scoreboard bench for mmc3_scanline_irq_ctrl: two instances (ALT_IRQ 0 and 1) driven identically,
// expectations from a rule-level model pushed per edge and popped by an independent monitor.
`timescale 1ns/1ps

module tb_mmc3_scanline_irq_ctrl;
  localparam int F = 3;

  logic        m2 = 1'b0;
  logic        rst_n = 1'b0;
  logic        romsel = 1'b1;
  logic        cpu_rw_in = 1'b1;
  logic [14:0] cpu_addr_in = '0;
  logic [7:0]  cpu_data_in = '0;
  logic        ppu_a12 = 1'b0;
  logic        irq_n0, irq_n1, ev0, ev1;
  logic [7:0]  ctr0, ctr1;

  mmc3_scanline_irq_ctrl #(.FILTER_CYCLES(F), .ALT_IRQ(0)) u_dut0 (
    .m2(m2), .rst_n(rst_n), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12),
    .irq_n(irq_n0), .irq_counter(ctr0), .a12_event(ev0));

  mmc3_scanline_irq_ctrl #(.FILTER_CYCLES(F), .ALT_IRQ(1)) u_dut1 (
    .m2(m2), .rst_n(rst_n), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12),
    .irq_n(irq_n1), .irq_counter(ctr1), .a12_event(ev1));

  always #5 m2 = ~m2;

  localparam logic [14:0] A_C000 = 15'h4000;
  localparam logic [14:0] A_C001 = 15'h4001;
  localparam logic [14:0] A_E000 = 15'h6000;
  localparam logic [14:0] A_E001 = 15'h6001;

  typedef struct {
    bit         ev;
    bit         irq_n0;
    logic [7:0] ctr0;
    bit         irq_n1;
    logic [7:0] ctr1;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state
  int m_latch[2];
  int m_ctr[2];
  bit m_reload[2];
  bit m_en[2];
  bit m_irq_n[2];
  bit m_wr_prev;
  bit hist[$];   // A12 value presented before each edge since reset, oldest first
  bit a12_cur = 1'b0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_latch[d]  = 0;
      m_ctr[d]    = 0;
      m_reload[d] = 0;
      m_en[d]     = 0;
      m_irq_n[d]  = 1;
    end
    m_wr_prev = 0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endtask

  // One rising edge: A12 seen two edges late, needs F low samples before its rise.
  task automatic model_step(bit rs, bit rw, logic [14:0] addr, logic [7:0] data, bit a12);
    exp_t     e;
    bit       ev;
    bit       wr;
    bit       commit;
    int       n;
    bit [2:0] sel;
    hist.push_back(a12);
    n  = hist.size();
    ev = 0;
    if (hist[n-3] == 1'b1 && (n - 3) >= F) begin
      ev = 1;
      for (int i = 1; i <= F; i++) if (hist[n-3-i] != 1'b0) ev = 0;
    end
    if (hist.size() > 20) void'(hist.pop_front());
    wr        = !rs && !rw;
    commit    = wr && !m_wr_prev;
    m_wr_prev = wr;
    sel       = {addr[14], addr[13], addr[0]};
    for (int d = 0; d < 2; d++) begin
      int old_ctr;
      bit old_rel;
      bit old_en;
      int nxt;
      old_ctr = m_ctr[d];
      old_rel = m_reload[d];
      old_en  = m_en[d];
      if (ev) begin
        nxt         = (old_ctr == 0 || old_rel) ? m_latch[d] : old_ctr - 1;
        m_ctr[d]    = nxt;
        m_reload[d] = 0;
        if (nxt == 0 && old_en && (d == 0 || old_ctr != 0 || old_rel) &&
            !(commit && sel == 3'b101))
          m_irq_n[d] = 0;
      end
      if (commit) begin
        case (sel)
          3'b100: m_latch[d] = int'(data);
          3'b101: begin m_ctr[d] = 0; m_reload[d] = 1; end
          3'b110: begin m_en[d] = 0; m_irq_n[d] = 1; end
          3'b111: m_en[d] = 1;
          default: ;
        endcase
      end
    end
    e.ev     = ev;
    e.irq_n0 = m_irq_n[0];
    e.ctr0   = 8'(m_ctr[0]);
    e.irq_n1 = m_irq_n[1];
    e.ctr1   = 8'(m_ctr[1]);
    exp_q.push_back(e);
  endtask

  task automatic step(bit rs, bit rw, logic [14:0] addr, logic [7:0] data, bit a12);
    @(negedge m2); #1;
    romsel = rs; cpu_rw_in = rw; cpu_addr_in = addr; cpu_data_in = data; ppu_a12 = a12;
    a12_cur = a12;
    model_step(rs, rw, addr, data, a12);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 15'h0, 8'h0, a12_cur);
  endtask

  task automatic wr_reg(logic [14:0] addr, logic [7:0] data, int hold);
    for (int i = 0; i < hold; i++) step(1'b0, 1'b0, addr, data, a12_cur);
    step(1'b1, 1'b1, addr, data, a12_cur);
  endtask

  task automatic rise(int low, int high);
    for (int i = 0; i < low; i++)  step(1'b1, 1'b1, 15'h0, 8'h0, 1'b0);
    for (int i = 0; i < high; i++) step(1'b1, 1'b1, 15'h0, 8'h0, 1'b1);
  endtask

  task automatic chk_reset(string nm, bit irqn, logic [7:0] c, bit ev);
    n_tests++;
    if (irqn !== 1'b1 || c !== 8'd0 || ev !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state %s: got irq_n=%0b ctr=%0d ev=%0b, expected irq_n=1 ctr=0 ev=0",
               nm, irqn, c, ev);
    end
  endtask

  // Async reset between edges; released before the next edge with no clock in between.
  task automatic reset_pulse();
    @(negedge m2); #1;
    rst_n = 1'b0;
    #1;
    chk_reset("dut0", irq_n0, ctr0, ev0);
    chk_reset("dut1", irq_n1, ctr1, ev1);
    #1;
    rst_n = 1'b1;
    model_reset();
    model_step(romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12);
  endtask

  // Monitor: compares every edge's outputs against the queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge m2); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (ev0 !== e.ev || irq_n0 !== e.irq_n0 || ctr0 !== e.ctr0) begin
          n_fail++;
          $display("FAIL edge_dut0 t=%0t: got ev=%0b irq_n=%0b ctr=%0d, expected ev=%0b irq_n=%0b ctr=%0d",
                   $time, ev0, irq_n0, ctr0, e.ev, e.irq_n0, e.ctr0);
        end
        n_tests++;
        if (ev1 !== e.ev || irq_n1 !== e.irq_n1 || ctr1 !== e.ctr1) begin
          n_fail++;
          $display("FAIL edge_dut1 t=%0t: got ev=%0b irq_n=%0b ctr=%0d, expected ev=%0b irq_n=%0b ctr=%0d",
                   $time, ev1, irq_n1, ctr1, e.ev, e.irq_n1, e.ctr1);
        end
      end
    end
  end

  initial begin : stim
    int         a12_run;
    int         wr_hold;
    logic [14:0] waddr;
    logic [7:0]  wdata;
    int         pick;
    model_reset();
    reset_pulse();

    // Basic count down 3,2,1,0 with IRQ on the 4th event
    idle(2);
    wr_reg(A_C000, 8'd3, 1);
    wr_reg(A_C001, 8'd0, 1);
    wr_reg(A_E001, 8'd0, 1);
    for (int i = 0; i < 4; i++) rise(8, 4);
    idle(3);

    // Acknowledge, then an event while disabled fires nothing
    wr_reg(A_E000, 8'd0, 1);
    rise(8, 4);
    idle(2);

    // Too-short low time is filtered out
    rise(2, 4);
    rise(2, 4);
    rise(1, 4);

    // Latch 0: ALT 0 fires every event, ALT 1 only the first
    wr_reg(A_C000, 8'd0, 1);
    wr_reg(A_C001, 8'd0, 1);
    wr_reg(A_E001, 8'd0, 1);
    for (int i = 0; i < 3; i++) begin
      rise(8, 4);
      wr_reg(A_E000, 8'd0, 1);
      wr_reg(A_E001, 8'd0, 1);
    end

    // $C001 held 5 cycles, first edge coincident with an event edge
    wr_reg(A_C000, 8'd5, 1);
    rise(8, 0);
    step(1'b1, 1'b1, 15'h0, 8'h0, 1'b1);
    step(1'b1, 1'b1, 15'h0, 8'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, A_C001, 8'h0, 1'b1);
    idle(1);
    rise(8, 4);
    rise(8, 4);

    // Reset in the middle of counting
    reset_pulse();
    idle(2);
    rise(8, 4);

    // Randomised traffic
    a12_run = 0;
    wr_hold = 0;
    waddr   = '0;
    wdata   = '0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) reset_pulse();
      if (a12_run == 0) begin
        a12_cur = ~a12_cur;
        a12_run = a12_cur ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 7));
      end
      a12_run--;
      if (wr_hold == 0 && $urandom_range(0, 7) == 0) begin
        wr_hold = $urandom_range(1, 4);
        pick    = $urandom_range(0, 4);
        waddr   = 15'($urandom);
        case (pick)
          0: begin waddr[14] = 1; waddr[13] = 0; waddr[0] = 0; end
          1: begin waddr[14] = 1; waddr[13] = 0; waddr[0] = 1; end
          2: begin waddr[14] = 1; waddr[13] = 1; waddr[0] = 0; end
          3: begin waddr[14] = 1; waddr[13] = 1; waddr[0] = 1; end
          default: waddr[14] = 0;
        endcase
        wdata = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      end
      if (wr_hold > 0) begin
        wr_hold--;
        step(1'b0, 1'b0, waddr, wdata, a12_cur);
      end else begin
        step(1'b1, ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1, waddr, wdata, a12_cur);
      end
    end

    repeat (4) @(posedge m2);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
